// File: rtl/mcdt_pkg.sv
// Shared types and helpers for the mcdt packet formatter slice.
package mcdt_pkg;

    localparam int unsigned NUM_CH = 3;

    typedef logic [1:0] ch_id_t;

    typedef enum logic [1:0] {IDLE, REQ, SEND} fmt_state_e;

    // (ch + step) mod NUM_CH for ch in 0..2, step in 0..3
    function automatic ch_id_t ch_add(input ch_id_t ch, input logic [1:0] step);
        logic [2:0] s;
        s = {1'b0, ch} + {1'b0, step};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

endpackage

// File: rtl/mcdt_fmt_fifo.sv
// Per-channel synchronous FIFO with a combinational head word and occupancy count.
module mcdt_fmt_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 32,
    parameter int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            push,
    input  logic [DW-1:0]   wdata,
    input  logic            pop,
    output logic [DW-1:0]   rdata,
    output logic [CNTW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    assign rdata = mem[rptr];

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mcdt_pkt_formatter.sv
// Buffers the arbitrated mcdt stream per channel and emits fixed-length packets
// round-robin over a req/grant handshake.
module mcdt_pkt_formatter
    import mcdt_pkg::*;
#(
    parameter int DW      = 32,
    parameter int DEPTH   = 32,
    parameter int PKT_LEN = 4,
    localparam int CNTW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [DW-1:0] in_data,
    input  logic          in_val,
    input  logic [1:0]    in_id,
    output logic          fmt_req,
    input  logic          fmt_grant,
    output logic [1:0]    fmt_chid,
    output logic          fmt_val,
    output logic [DW-1:0] fmt_data,
    output logic          fmt_start,
    output logic          fmt_end,
    output logic [2:0]    ovf,
    output logic          bad_id
);

    localparam logic [CNTW-1:0] PKT_LEN_C = CNTW'(PKT_LEN);
    localparam logic [CNTW-1:0] LAST_C    = CNTW'(PKT_LEN - 1);
    localparam logic [CNTW-1:0] FULL_C    = CNTW'(DEPTH);

    fmt_state_e         state;
    ch_id_t             rr;
    logic [CNTW-1:0]    wcnt;
    logic [CNTW-1:0]    cnt  [NUM_CH];
    logic [DW-1:0]      head [NUM_CH];
    logic [NUM_CH-1:0]  push;
    logic [NUM_CH-1:0]  pop;
    logic [NUM_CH-1:0]  elig;
    logic [NUM_CH-1:0]  ovf_set;
    logic               last_word;
    logic               pick_ok;
    ch_id_t             pick;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
        mcdt_fmt_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH),
            .CNTW  (CNTW)
        ) u_fifo (
            .clk   (clk),
            .rstn  (rstn),
            .push  (push[g]),
            .wdata (in_data),
            .pop   (pop[g]),
            .rdata (head[g]),
            .count (cnt[g])
        );
    end

    assign last_word = (wcnt == LAST_C);

    // A full FIFO still accepts a word when the packet path pops it in the same cycle.
    always_comb begin
        push    = '0;
        pop     = '0;
        elig    = '0;
        ovf_set = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            pop[n]  = (fmt_chid == ch_id_t'(n)) &&
                      (((state == REQ) && fmt_grant) || ((state == SEND) && !last_word));
            elig[n] = (cnt[n] >= PKT_LEN_C);
            if (in_val && (in_id == ch_id_t'(n))) begin
                if ((cnt[n] < FULL_C) || pop[n]) push[n]    = 1'b1;
                else                             ovf_set[n] = 1'b1;
            end
        end
    end

    always_comb begin
        ch_id_t cand;
        pick_ok = 1'b0;
        pick    = rr;
        cand    = rr;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand = ch_add(rr, 2'(k));
            if (!pick_ok && elig[cand]) begin
                pick_ok = 1'b1;
                pick    = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state     <= IDLE;
            rr        <= 2'd2;
            wcnt      <= '0;
            fmt_req   <= 1'b0;
            fmt_chid  <= '0;
            fmt_val   <= 1'b0;
            fmt_data  <= '0;
            fmt_start <= 1'b0;
            fmt_end   <= 1'b0;
            ovf       <= '0;
            bad_id    <= 1'b0;
        end else begin
            ovf <= ovf | ovf_set;
            if (in_val && (in_id == 2'd3)) bad_id <= 1'b1;
            case (state)
                IDLE: begin
                    if (pick_ok) begin
                        fmt_chid <= pick;
                        rr       <= pick;
                        fmt_req  <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (fmt_grant) begin
                        fmt_req   <= 1'b0;
                        fmt_val   <= 1'b1;
                        fmt_data  <= head[fmt_chid];
                        fmt_start <= 1'b1;
                        fmt_end   <= (LAST_C == '0);
                        wcnt      <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (last_word) begin
                        fmt_val   <= 1'b0;
                        fmt_start <= 1'b0;
                        fmt_end   <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        fmt_data  <= head[fmt_chid];
                        fmt_start <= 1'b0;
                        fmt_end   <= ((wcnt + 1'b1) == LAST_C);
                        wcnt      <= wcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcdt_pkt_formatter.sv
// Randomized and directed bench for mcdt_pkt_formatter against a queue-based packet model.
module tb_mcdt_pkt_formatter;

    localparam int DW      = 32;
    localparam int DEPTH   = 32;
    localparam int PKT_LEN = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_val = 1'b0;
    logic [1:0]    in_id = '0;
    logic          fmt_grant = 1'b0;
    logic          fmt_req;
    logic [1:0]    fmt_chid;
    logic          fmt_val;
    logic [DW-1:0] fmt_data;
    logic          fmt_start;
    logic          fmt_end;
    logic [2:0]    ovf;
    logic          bad_id;

    always #5 clk = ~clk;

    mcdt_pkt_formatter #(
        .DW      (DW),
        .DEPTH   (DEPTH),
        .PKT_LEN (PKT_LEN)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data),
        .in_val    (in_val),
        .in_id     (in_id),
        .fmt_req   (fmt_req),
        .fmt_grant (fmt_grant),
        .fmt_chid  (fmt_chid),
        .fmt_val   (fmt_val),
        .fmt_data  (fmt_data),
        .fmt_start (fmt_start),
        .fmt_end   (fmt_end),
        .ovf       (ovf),
        .bad_id    (bad_id)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: per-channel word queues plus packet progress
    logic [DW-1:0] mq [3][$];
    int            m_mode;   // 0 waiting, 1 requesting, 2 sending
    int            m_chid;
    int            m_rr;
    int            m_idx;
    bit            e_req, e_val, e_start, e_end, e_bad;
    logic [2:0]    e_ovf;
    logic [DW-1:0] e_data;

    function automatic void model_reset();
        for (int c = 0; c < 3; c++) mq[c].delete();
        m_mode = 0; m_chid = 0; m_rr = 2; m_idx = 0;
        e_req = 0; e_val = 0; e_start = 0; e_end = 0; e_bad = 0;
        e_ovf = '0; e_data = '0;
    endfunction

    task automatic model_step();
        int pre [3];
        bit dec = 0;
        bit popped = 0;
        for (int c = 0; c < 3; c++) pre[c] = mq[c].size();
        case (m_mode)
            0: begin
                for (int k = 1; k <= 3; k++) begin
                    int c;
                    c = (m_rr + k) % 3;
                    if (!dec && pre[c] >= PKT_LEN) begin
                        dec = 1; m_chid = c; m_rr = c; m_mode = 1; e_req = 1;
                    end
                end
            end
            1: begin
                if (fmt_grant) begin
                    e_req = 0; m_mode = 2; m_idx = 0;
                    e_val = 1; e_start = 1; e_end = (PKT_LEN == 1);
                    e_data = mq[m_chid].pop_front();
                    popped = 1;
                end
            end
            default: begin
                if (m_idx == PKT_LEN - 1) begin
                    e_val = 0; e_start = 0; e_end = 0; m_mode = 0;
                end else begin
                    m_idx++;
                    e_data = mq[m_chid].pop_front();
                    popped = 1;
                    e_start = 0;
                    e_end = (m_idx == PKT_LEN - 1);
                end
            end
        endcase
        if (in_val) begin
            if (in_id == 2'd3) e_bad = 1;
            else if (pre[in_id] < DEPTH || (popped && m_chid == int'(in_id)))
                mq[in_id].push_back(in_data);
            else e_ovf[in_id] = 1'b1;
        end
    endtask

    task automatic check_outputs();
        check("fmt_req",   64'(fmt_req),   64'(e_req));
        check("fmt_chid",  64'(fmt_chid),  64'(m_chid));
        check("fmt_val",   64'(fmt_val),   64'(e_val));
        check("fmt_start", 64'(fmt_start), 64'(e_start));
        check("fmt_end",   64'(fmt_end),   64'(e_end));
        check("ovf",       64'(ovf),       64'(e_ovf));
        check("bad_id",    64'(bad_id),    64'(e_bad));
        if (e_val) check("fmt_data", 64'(fmt_data), 64'(e_data));
    endtask

    // Called at a negedge; drives one cycle of inputs and checks after the edge.
    task automatic cycle(input logic v, input logic [1:0] id, input logic [DW-1:0] d, input logic g);
        in_val = v; in_id = id; in_data = d; fmt_grant = g;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic g);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, '0, g);
    endtask

    task automatic push_words(input logic [1:0] id, input logic [DW-1:0] base, input int n, input logic g);
        for (int i = 0; i < n; i++) cycle(1'b1, id, base + DW'(i), g);
    endtask

    int            seq;
    int            starts [$];
    logic [DW-1:0] first_w, last_w;
    bit            hit;

    initial begin
        model_reset();
        // 1: reset state and quiet idle
        @(negedge clk);
        @(posedge clk); #1;
        check_outputs();
        @(negedge clk);
        rstn = 1'b0;
        idle(6, 1'b1);

        // 2: single ch0 packet
        push_words(2'd0, 32'h00C00000, 4, 1'b1);
        first_w = '0; last_w = '0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 2'd0, '0, 1'b1);
            if (fmt_val && fmt_start) first_w = fmt_data;
            if (fmt_val && fmt_end)   last_w  = fmt_data;
        end
        check("t2_first", 64'(first_w), 64'h00C00000);
        check("t2_last",  64'(last_w),  64'h00C00003);

        // 3: round-robin order over two refills
        for (int r = 0; r < 2; r++) begin
            starts.delete();
            for (int c = 0; c < 3; c++) begin
                for (int i = 0; i < 4; i++) begin
                    cycle(1'b1, 2'(c), 32'h00C30000 + DW'(r * 16 + c * 4 + i), 1'b1);
                    if (fmt_val && fmt_start) starts.push_back(int'(fmt_chid));
                end
            end
            for (int i = 0; i < 30; i++) begin
                cycle(1'b0, 2'd0, '0, 1'b1);
                if (fmt_val && fmt_start) starts.push_back(int'(fmt_chid));
            end
            check("t3_npkt", 64'(starts.size()), 64'd3);
            for (int k = 0; k < 3; k++)
                check("t3_order", 64'(k < starts.size() ? starts[k] : 9), 64'(k));
        end

        // 4: overflow on ch1 with no grant, then drain
        push_words(2'd1, 32'h00C10000, 33, 1'b0);
        check("t4_ovf", 64'(ovf), 64'(3'b010));
        seq = 0;
        for (int i = 0; i < 120; i++) begin
            cycle(1'b0, 2'd0, '0, 1'b1);
            if (fmt_val && fmt_chid == 2'd1) begin
                check("t4_seq", 64'(fmt_data), 64'(32'h00C10000 + DW'(seq)));
                seq++;
            end
        end
        check("t4_count", 64'(seq), 64'd32);

        // 5: illegal channel id
        push_words(2'd3, 32'h00C3DEAD, 5, 1'b1);
        idle(4, 1'b1);
        check("t5_bad_id", 64'(bad_id), 64'd1);
        check("t5_no_req", 64'(fmt_req), 64'd0);

        // 6: reset in the middle of a ch2 packet
        push_words(2'd2, 32'h00C20000, 4, 1'b1);
        seq = 0; hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            cycle(1'b0, 2'd0, '0, 1'b1);
            if (fmt_val) seq++;
            if (seq == 2) hit = 1;
        end
        check("t6_reach", 64'(hit), 64'd1);
        rstn = 1'b1;
        #1;
        model_reset();
        check("t6_val_drop", 64'(fmt_val), 64'd0);
        check("t6_req_drop", 64'(fmt_req), 64'd0);
        @(posedge clk); #1;
        check_outputs();
        @(negedge clk);
        rstn = 1'b0;
        idle(5, 1'b1);
        push_words(2'd0, 32'h00C60000, 3, 1'b0);
        idle(4, 1'b0);
        check("t6_no_req", 64'(fmt_req), 64'd0);
        push_words(2'd0, 32'h00C60003, 1, 1'b0);
        idle(2, 1'b0);
        check("t6_req", 64'(fmt_req), 64'd1);
        idle(12, 1'b1);

        // Random traffic with random grants
        for (int i = 0; i < 600; i++) begin
            logic [1:0] rid;
            rid = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            cycle(1'($urandom_range(0, 9) < 7), rid, DW'($urandom), 1'($urandom_range(0, 1)));
        end
        idle(200, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
